// File: rtl/mode4_pkg.sv
// fp16 field layout and shared constants for the softmax exp-sum stage.
package mode4_pkg;

    localparam int EXP_W    = 5;
    localparam int MAN_W    = 10;
    localparam int EXP_LSB  = 10;
    localparam int EXP_MSB  = 14;
    localparam int SIGN_BIT = 15;

    localparam logic [EXP_W-1:0] EXP_INF   = 5'h1F;
    localparam logic [15:0]      FP16_INF  = 16'h7C00;
    localparam logic [15:0]      FP16_ZERO = 16'h0000;

    localparam int LANES         = 4;
    localparam int NUM_WORDS_DEF = 32;

    function automatic int beats_of(input int num_words);
        return num_words / LANES;
    endfunction

    function automatic logic exp_is_inf(input logic [15:0] x);
        return x[EXP_MSB:EXP_LSB] == EXP_INF;
    endfunction

endpackage

// File: rtl/mode4_exp_sum_fp16_uadd.sv
// Combinational unsigned fp16 adder: signs ignored, subnormals flushed,
// alignment shift truncates, inf/NaN or exponent overflow yields 0x7C00.
module fp16_uadd
    import mode4_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);

    logic [EXP_W-1:0] ea, eb, ex, ey, ed;
    logic [MAN_W:0]   mx, my, mys;
    logic [MAN_W+1:0] msum;
    logic [EXP_W:0]   eo;
    logic [MAN_W-1:0] mo;

    always_comb begin
        ea = a[EXP_MSB:EXP_LSB];
        eb = b[EXP_MSB:EXP_LSB];
        if (ea >= eb) begin
            ex = ea;
            ey = eb;
            mx = {1'b1, a[MAN_W-1:0]};
            my = {1'b1, b[MAN_W-1:0]};
        end else begin
            ex = eb;
            ey = ea;
            mx = {1'b1, b[MAN_W-1:0]};
            my = {1'b1, a[MAN_W-1:0]};
        end
        ed   = ex - ey;
        mys  = my >> ed;
        msum = {1'b0, mx} + {1'b0, mys};
        // A carry out of the hidden bit renormalises by one; the dropped LSB truncates.
        if (msum[MAN_W+1]) begin
            eo = {1'b0, ex} + (EXP_W+1)'(1);
            mo = msum[MAN_W:1];
        end else begin
            eo = {1'b0, ex};
            mo = msum[MAN_W-1:0];
        end

        y = FP16_ZERO;
        if (ea == EXP_INF || eb == EXP_INF)
            y = FP16_INF;
        else if (ea == '0 && eb == '0)
            y = FP16_ZERO;
        else if (ea == '0)
            y = {1'b0, b[SIGN_BIT-1:0]};
        else if (eb == '0)
            y = {1'b0, a[SIGN_BIT-1:0]};
        else if (eo >= {1'b0, EXP_INF})
            y = FP16_INF;
        else if (eo == '0)
            y = FP16_ZERO;
        else
            y = {1'b0, eo[EXP_W-1:0], mo};
    end

endmodule

// File: rtl/mode4_exp_sum.sv
// Row reducer for the 4-lane exp stage: 2-level adder tree plus row accumulator.
// Optional MODE4_EXP_SUM_OVF_EN adds a sticky per-row ovf output.
module mode4_exp_sum
    import mode4_pkg::*;
#(
    parameter int DATAWIDTH = 16,
    parameter int NUM_WORDS = NUM_WORDS_DEF,
    parameter int BEATS     = beats_of(NUM_WORDS),
    parameter int CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stage_run,
    input  logic [DATAWIDTH-1:0] inp0,
    input  logic [DATAWIDTH-1:0] inp1,
    input  logic [DATAWIDTH-1:0] inp2,
    input  logic [DATAWIDTH-1:0] inp3,
    output logic [DATAWIDTH-1:0] sum,
    output logic                 sum_valid,
`ifdef MODE4_EXP_SUM_OVF_EN
    output logic                 ovf,
`endif
    output logic                 busy
);

    logic [DATAWIDTH-1:0] s01_d, s23_d, t_d, acc_sum, acc_next;
    logic [DATAWIDTH-1:0] s01_q, s23_q, t_q, acc;
    logic                 v1, v2, busy_q;
    logic [CNT_W-1:0]     cnt;
    logic                 last, row_done;

    fp16_uadd u_add01 (.a(inp0),  .b(inp1),  .y(s01_d));
    fp16_uadd u_add23 (.a(inp2),  .b(inp3),  .y(s23_d));
    fp16_uadd u_add_t (.a(s01_q), .b(s23_q), .y(t_d));
    fp16_uadd u_add_a (.a(acc),   .b(t_q),   .y(acc_sum));

    assign last     = (cnt == CNT_W'(BEATS - 1));
    assign row_done = v2 && last;
    assign acc_next = (cnt == '0) ? t_q : acc_sum;
    assign busy     = busy_q | (stage_run & ~reset);

    always_ff @(posedge clk) begin
        if (reset) begin
            s01_q     <= FP16_ZERO;
            s23_q     <= FP16_ZERO;
            t_q       <= FP16_ZERO;
            acc       <= FP16_ZERO;
            sum       <= FP16_ZERO;
            v1        <= 1'b0;
            v2        <= 1'b0;
            cnt       <= '0;
            sum_valid <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            v1 <= stage_run;
            if (stage_run) begin
                s01_q <= s01_d;
                s23_q <= s23_d;
            end
            v2 <= v1;
            if (v1)
                t_q <= t_d;
            sum_valid <= 1'b0;
            if (v2) begin
                acc <= acc_next;
                if (last) begin
                    cnt       <= '0;
                    sum       <= acc_next;
                    sum_valid <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
            // A beat of the next row already in stage 1 keeps busy up.
            if (stage_run)
                busy_q <= 1'b1;
            else if (row_done)
                busy_q <= v1;
        end
    end

`ifdef MODE4_EXP_SUM_OVF_EN
    logic f1, f2, row_ovf, ovf_next, in_inf;

    assign in_inf   = exp_is_inf(inp0) | exp_is_inf(inp1) | exp_is_inf(inp2) | exp_is_inf(inp3);
    assign ovf_next = f2 | ((cnt != '0) & (row_ovf | (acc_sum == FP16_INF)));

    always_ff @(posedge clk) begin
        if (reset) begin
            f1      <= 1'b0;
            f2      <= 1'b0;
            row_ovf <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            if (stage_run)
                f1 <= in_inf | (s01_d == FP16_INF) | (s23_d == FP16_INF);
            if (v1)
                f2 <= f1 | (t_d == FP16_INF);
            if (v2) begin
                row_ovf <= ovf_next;
                if (last)
                    ovf <= ovf_next;
            end
        end
    end
`endif

endmodule
